// File: rtl/pong_pkg.sv
// Shared playfield constants and paddle motion types, also used by the ball block.
// step_pos holds the clamped position arithmetic so every user of a paddle agrees on the limits.
package pong_pkg;

  localparam int SCREEN_H = 480;
  localparam int PAD_HALF = 20;

  localparam logic [9:0] POS_MIN = 10'(PAD_HALF);
  localparam logic [9:0] POS_MAX = 10'(SCREEN_H - 1 - PAD_HALF);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } paddle_dir_t;

  function automatic paddle_dir_t dir_from_buttons(input logic up, input logic dn);
    paddle_dir_t dir;
    dir = DIR_IDLE;
    if (up && !dn) dir = DIR_UP;
    else if (dn && !up) dir = DIR_DOWN;
    return dir;
  endfunction

  // 11-bit working width: an upward step below zero shows up as bit 10 set,
  // so the clamp lands exactly on the limit instead of wrapping.
  function automatic logic [9:0] step_pos(input logic [9:0] pos,
                                          input paddle_dir_t dir,
                                          input logic [1:0] step);
    logic [10:0] ext;
    logic [10:0] sum;
    ext = {1'b0, pos};
    sum = ext;
    case (dir)
      DIR_UP: begin
        sum = ext - {9'd0, step};
        if (sum[10] || (sum < {1'b0, POS_MIN})) sum = {1'b0, POS_MIN};
      end
      DIR_DOWN: begin
        sum = ext + {9'd0, step};
        if (sum > {1'b0, POS_MAX}) sum = {1'b0, POS_MAX};
      end
      default: sum = ext;
    endcase
    return sum[9:0];
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Board-side bundle for one paddle: raw active-low buttons in, centre position and motion state out.
// master is the board/test side, slave is the paddle controller side.
interface paddle_ctrl_if;

  logic       btn_up_n;
  logic       btn_down_n;
  logic [9:0] paddle_pos;
  logic [1:0] paddle_dir;

  modport master (
    output btn_up_n,
    output btn_down_n,
    input  paddle_pos,
    input  paddle_dir
  );

  modport slave (
    input  btn_up_n,
    input  btn_down_n,
    output paddle_pos,
    output paddle_dir
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter for one raw active-low button.
// level is active-high and only changes after DEB_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed;

  assign pressed = ~sync2_q;
  assign level   = level_q;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    // Any sample agreeing with the current level restarts the stability window.
    if (pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = pressed;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: debounced buttons drive an IDLE/UP/DOWN FSM that moves the paddle
// centre once per prescaler tick, with clamping at the playfield edges and hold acceleration.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_BITS   = 17,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int RESET_POS   = 240,
  parameter int ACCEL_TICKS = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  output logic [9:0] paddle_pos,
  output logic [1:0] paddle_dir
);

  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [HW-1:0] ACCEL_LIM = HW'(ACCEL_TICKS);

  logic up;
  logic dn;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (btn_up_n),
    .level   (up)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (btn_down_n),
    .level   (dn)
  );

  logic [TICK_BITS-1:0] tick_cnt_q, tick_cnt_d;
  logic                 tick;
  paddle_dir_t          state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [9:0]           pos_q, pos_d;
  logic [1:0]           step;

  assign tick = &tick_cnt_q;
  assign step = (hold_q >= ACCEL_LIM) ? 2'd2 : 2'd1;

  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_BITS'(1);
    state_d    = dir_from_buttons(up, dn);
    hold_d     = hold_q;
    // A state change wins over a coincident tick: the counter restarts rather than counting.
    if ((state_d != state_q) || (state_q == DIR_IDLE)) begin
      hold_d = '0;
    end else if (tick && (hold_q != ACCEL_LIM)) begin
      hold_d = hold_q + HW'(1);
    end
    // The move uses the registered state, so a same-clock change only affects later ticks.
    pos_d = pos_q;
    if (tick) pos_d = step_pos(pos_q, state_q, step);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      state_q    <= DIR_IDLE;
      hold_q     <= '0;
      pos_q      <= 10'(RESET_POS);
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      pos_q      <= pos_d;
    end
  end

  assign paddle_pos = pos_q;
  assign paddle_dir = state_q;

  ap_dir_legal : assert property (@(posedge clk) disable iff (!reset_n)
    state_q != 2'b11);

  ap_pos_in_field : assert property (@(posedge clk) disable iff (!reset_n)
    (pos_q >= POS_MIN) && (pos_q <= POS_MAX));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with short tick/debounce/accel parameters.
// Button changes are applied just after a move edge so each takes effect before the next tick.
module tb_paddle_ctrl;

  localparam int TB_TICK_BITS   = 4;
  localparam int TB_DEB_CYCLES  = 8;
  localparam int TB_ACCEL_TICKS = 4;
  localparam int TICK_PERIOD    = 1 << TB_TICK_BITS;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_miss;

  paddle_ctrl_if pif ();

  paddle_ctrl #(
    .TICK_BITS   (TB_TICK_BITS),
    .DEB_CYCLES  (TB_DEB_CYCLES),
    .RESET_POS   (240),
    .ACCEL_TICKS (TB_ACCEL_TICKS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_up_n   (pif.btn_up_n),
    .btn_down_n (pif.btn_down_n),
    .paddle_pos (pif.paddle_pos),
    .paddle_dir (pif.paddle_dir)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clocks since reset release; moves happen on edges where this is a multiple of TICK_PERIOD.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the negedge just after the n-th following move edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while ((cyc % TICK_PERIOD) != 0) @(negedge clk);
    end
  endtask

  task automatic align();
    @(negedge clk);
    while ((cyc % TICK_PERIOD) != 0) @(negedge clk);
  endtask

  task automatic set_btns(input logic up_n, input logic dn_n);
    pif.btn_up_n   = up_n;
    pif.btn_down_n = dn_n;
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    reset_n = 1'b0;
    set_btns(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("reset_pos", 16'(pif.paddle_pos), 16'd240);
    check("reset_dir", 16'(pif.paddle_dir), 16'd0);
    reset_n = 1'b1;

    repeat (200) @(negedge clk);
    check("idle_pos", 16'(pif.paddle_pos), 16'd240);
    check("idle_dir", 16'(pif.paddle_dir), 16'd0);

    // Bounce: 3-clock runs never satisfy the 8-clock window.
    align();
    for (int i = 0; i < 20; i++) begin
      pif.btn_up_n = ~pif.btn_up_n;
      repeat (3) @(negedge clk);
      check("bounce_dir", 16'(pif.paddle_dir), 16'd0);
    end
    pif.btn_up_n = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_pos", 16'(pif.paddle_pos), 16'd240);

    // Hold up: 2 sync + 8 debounce + 1 FSM clock.
    align();
    set_btns(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("up_dir_early", 16'(pif.paddle_dir), 16'd0);
    @(negedge clk);
    check("up_dir", 16'(pif.paddle_dir), 16'd1);
    ticks(1); check("up_pos1", 16'(pif.paddle_pos), 16'd239);
    ticks(1); check("up_pos2", 16'(pif.paddle_pos), 16'd238);
    ticks(1); check("up_pos3", 16'(pif.paddle_pos), 16'd237);
    ticks(1); check("up_pos4", 16'(pif.paddle_pos), 16'd236);
    ticks(1); check("up_acc1", 16'(pif.paddle_pos), 16'd234);
    ticks(1); check("up_acc2", 16'(pif.paddle_pos), 16'd232);
    set_btns(1'b1, 1'b1);
    repeat (11) @(negedge clk);
    check("rel_dir", 16'(pif.paddle_dir), 16'd0);
    ticks(2);
    check("rel_pos", 16'(pif.paddle_pos), 16'd232);

    // One single down step to reach an odd position.
    set_btns(1'b1, 1'b0);
    ticks(1);
    check("dn_dir", 16'(pif.paddle_dir), 16'd2);
    check("dn_one", 16'(pif.paddle_pos), 16'd233);
    set_btns(1'b1, 1'b1);
    ticks(1);
    check("dn_hold", 16'(pif.paddle_pos), 16'd233);

    // Clamp at the bottom: 234..237 at step 1, then step 2 up to 455, 457, 459.
    set_btns(1'b1, 1'b0);
    ticks(4);   check("dn_slow", 16'(pif.paddle_pos), 16'd237);
    ticks(109); check("dn_455", 16'(pif.paddle_pos), 16'd455);
    ticks(1);   check("dn_457", 16'(pif.paddle_pos), 16'd457);
    ticks(1);   check("dn_459", 16'(pif.paddle_pos), 16'd459);
    ticks(2);   check("dn_clamp", 16'(pif.paddle_pos), 16'd459);

    // Direct DOWN->UP, then clamp at the top: 458..455 at step 1, step 2 to 21, then 20.
    set_btns(1'b0, 1'b1);
    ticks(4);   check("upc_slow", 16'(pif.paddle_pos), 16'd455);
    ticks(217); check("upc_21", 16'(pif.paddle_pos), 16'd21);
    ticks(1);   check("upc_20", 16'(pif.paddle_pos), 16'd20);
    ticks(2);   check("upc_clamp", 16'(pif.paddle_pos), 16'd20);

    // Reversal from UP at step 2: first DOWN move is +1.
    set_btns(1'b1, 1'b0);
    ticks(1);
    check("rev_dir", 16'(pif.paddle_dir), 16'd2);
    check("rev_pos1", 16'(pif.paddle_pos), 16'd21);
    ticks(1);
    check("rev_pos2", 16'(pif.paddle_pos), 16'd22);

    // Both pressed is IDLE; releasing up alone gives DOWN with step 1.
    set_btns(1'b1, 1'b1);
    ticks(1);
    check("both_pre", 16'(pif.paddle_pos), 16'd22);
    set_btns(1'b0, 1'b0);
    ticks(2);
    check("both_dir", 16'(pif.paddle_dir), 16'd0);
    check("both_pos", 16'(pif.paddle_pos), 16'd22);
    pif.btn_up_n = 1'b1;
    repeat (11) @(negedge clk);
    check("both_rel_dir", 16'(pif.paddle_dir), 16'd2);
    ticks(1); check("both_step1", 16'(pif.paddle_pos), 16'd23);
    ticks(1); check("both_step2", 16'(pif.paddle_pos), 16'd24);

    // Asynchronous reset mid-motion, checked before any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_pos", 16'(pif.paddle_pos), 16'd240);
    check("areset_dir", 16'(pif.paddle_dir), 16'd0);
    set_btns(1'b1, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_reset_pos", 16'(pif.paddle_pos), 16'd240);
    check("post_reset_dir", 16'(pif.paddle_dir), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Converts the two raw, active-low board push-buttons for one paddle into the paddle's vertical centre position. The output drives the ball block's `right_paddle_pos` input and the display stage. Button inputs are synchronised and debounced. The paddle moves on a slow free-running tick, clamps at the playfield edges and accelerates while a button is held.

## Interface
Parameters:
- `TICK_BITS`, default 17: width of the move-tick prescaler. One tick every 2^TICK_BITS clocks.
- `DEB_CYCLES`, default 1_000_000: consecutive stable synchronised clocks required before a debounced level changes.
- `RESET_POS`, default 240: paddle centre y after reset.
- `ACCEL_TICKS`, default 32: number of held ticks in one direction before the step rises from 1 to 2.

Ports (clock and reset first):
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_up_n`  in  1  raw up button, active-low, asynchronous to `clk`.
- `btn_down_n`  in  1  raw down button, active-low, asynchronous to `clk`.
- `paddle_pos`  out  10  paddle centre y, in pixels. Rows grow downward.
- `paddle_dir`  out  2  current motion state: 00 idle, 01 up, 10 down. 11 is never driven.

## Operation
- Input path, per button:
  - 2-flop synchroniser, reset to 1 (released).
  - Debounce counter. The debounced level changes only after the synchronised level has differed from it for `DEB_CYCLES` consecutive clocks.
  - Any sample equal to the current debounced level clears the counter.
  - The debounced signal is active-high: `up`, `dn`.
- Prescaler: free-running `TICK_BITS` counter. `tick` is a one-cycle pulse when the counter is all ones; the counter then wraps to 0.
- Motion FSM, states IDLE, UP and DOWN. Evaluated every clock from the debounced `up`/`dn`:
  - `up` & !`dn` → UP
  - `dn` & !`up` → DOWN
  - both or neither → IDLE
- Hold counter:
  - Counts ticks spent in the current non-IDLE state, saturating at `ACCEL_TICKS`.
  - Clears on any state change, including UP↔DOWN directly, and while IDLE.
- Step size: 1 while the hold counter < `ACCEL_TICKS`, otherwise 2.
- Position update, only on the clock where `tick`=1:
  - UP: `paddle_pos` ← max(`paddle_pos` − step, `POS_MIN`).
  - DOWN: `paddle_pos` ← min(`paddle_pos` + step, `POS_MAX`).
  - IDLE: hold.
- Arithmetic:
  - Computed in 11 bits so the subtraction cannot wrap below 0.
  - Clamping saturates to the limit exactly; it never stops short and never bounces.
  - `POS_MIN` = `PAD_HALF` = 20. `POS_MAX` = `SCREEN_H` − 1 − `PAD_HALF` = 459.
- `paddle_dir` is the registered FSM state.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `paddle_pos` = `RESET_POS`, `paddle_dir` = 00.
  - Synchronisers = 1, debounced levels = 0.
  - All counters = 0, FSM = IDLE.
- Button press to debounced change: 2 synchroniser clocks + `DEB_CYCLES` clocks.
- Debounced change to `paddle_dir`: 1 clock.
- `paddle_pos` changes only on the clock edge where `tick`=1. It moves at most once per tick and is stable for 2^TICK_BITS − 1 clocks between updates.
- If a state change and `tick` fall on the same clock:
  - The position update uses the registered (old) state.
  - The hold counter clears; it does not increment.
- Reset asserted mid-motion: the outputs return to reset values immediately, without waiting for a clock edge.
- Glitches shorter than `DEB_CYCLES` never reach the FSM.

## Structure
- Shared package `pong_pkg` holds:
  - `SCREEN_H` = 480, `PAD_HALF` = 20 (also used by the ball block), `POS_MIN`, `POS_MAX`.
  - `typedef enum logic [1:0] {DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10} paddle_dir_t`.
- Sub-module `btn_debounce` contains the synchroniser and debounce counter, with parameter `DEB_CYCLES`. It is instantiated twice. Counter width is $clog2(`DEB_CYCLES`+1).
- The prescaler, FSM, hold counter and position register live in the top module.

## Test plan
Bench parameters: `TICK_BITS`=4, `DEB_CYCLES`=8, `ACCEL_TICKS`=4.
- Reset: assert `reset_n`=0 mid-run → `paddle_pos`=240 and `paddle_dir`=00 asynchronously; after release, the position is held for 200 clocks with no buttons pressed.
- Bounce: toggle `btn_up_n` every 3 clocks for 60 clocks, then release → `paddle_dir` stays 00 and `paddle_pos` stays 240.
- Hold up: press `btn_up_n` → `paddle_dir`=01 after 11 clocks. Position then reads 239, 238, 237, 236 on successive ticks, then decreases by 2 per tick (234, 232, ...). Release → 00 and the position freezes.
- Clamp: hold down from 455 with step 2 → 457, 459, 459, ...; never 460 or more, never wraps. Hold up near the top → saturates at exactly 20.
- Both pressed: press both buttons together → `paddle_dir`=00 and the position is held. Release up only → 10 after debounce, and the step restarts at 1.
- Reversal: while in UP with step 2, switch directly to down → DOWN, and the first update is +1 (hold counter cleared).
